// File: rtl/writeback_unit_pkg.sv
// Shared types for the register-file writeback path: load sizes, writeback FSM states,
// queued load entries and the load extension helper.
package riscv_wb_pkg;

  localparam int WB_XLEN = 64;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} ld_size_e;

  typedef enum logic [1:0] {WB_RUN, WB_DRAIN, WB_HALTED} wb_state_e;

  // Entry width follows WB_XLEN; instantiate the unit with BUS_DATA_WIDTH equal to it.
  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic [WB_XLEN-1:0] wb_extend(logic [WB_XLEN-1:0] d, ld_size_e sz,
                                                   logic uns);
    logic [WB_XLEN-1:0] r;
    r = d;
    case (sz)
      SZ_B:    r = {{(WB_XLEN-8){~uns & d[7]}}, d[7:0]};
      SZ_H:    r = {{(WB_XLEN-16){~uns & d[15]}}, d[15:0]};
      SZ_W:    r = {{(WB_XLEN-32){~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// ALU / load-unit / register-file write port bundle of the writeback unit.
interface writeback_unit_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LQ_DEPTH       = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic                      alu_valid;
  logic                      alu_ready;
  logic [4:0]                alu_rd;
  logic [BUS_DATA_WIDTH-1:0] alu_result;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [4:0]                ld_rd;
  logic [BUS_DATA_WIDTH-1:0] ld_data;
  logic [1:0]                ld_size;
  logic                      ld_unsigned;
  logic                      halt_req;
  logic                      wr_en;
  logic [4:0]                wr_rd;
  logic [BUS_DATA_WIDTH-1:0] wr_data;
  logic [CNT_W-1:0]          pending_count;
  logic                      halt_done;

  modport slave (
    input  alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
           halt_req,
    output alu_ready, ld_ready, wr_en, wr_rd, wr_data, pending_count, halt_done
  );

  modport master (
    output alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
           halt_req,
    input  alu_ready, ld_ready, wr_en, wr_rd, wr_data, pending_count, halt_done
  );

endinterface

// File: rtl/writeback_unit_load_fifo.sv
// Circular load queue; exposes per-entry valid/rd so the owner can run the RAW/WAW compare.
module wb_load_fifo
  import riscv_wb_pkg::*;
#(
  parameter int  LQ_DEPTH = 4,
  localparam int PW       = $clog2(LQ_DEPTH),
  localparam int CW       = $clog2(LQ_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic [CW-1:0]            count_o,
  output logic [LQ_DEPTH-1:0]      ent_valid_o,
  output logic [LQ_DEPTH-1:0][4:0] ent_rd_o
);

  wb_entry_t [LQ_DEPTH-1:0] mem_q;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Slot i is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off            = PW'(i) - rd_ptr_q;
    assign ent_valid_o[i] = CW'(off) < count_q;
    assign ent_rd_o[i]    = mem_q[i].rd;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter: ALU first, queued extended loads otherwise, halt drain.
// Optional WB_TRACE_EN prints every committed write and the halt event.
module writeback_unit
  import riscv_wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = WB_XLEN,
  parameter int LQ_DEPTH       = 4
) (
  input logic            clk,
  input logic            reset,
  writeback_unit_if.slave bus
);

  localparam int CW = $clog2(LQ_DEPTH + 1);

  wb_state_e                 state_q, state_d;
  logic                      wr_en_q, wr_en_d;
  logic [4:0]                wr_rd_q, wr_rd_d;
  logic [BUS_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [CW-1:0]             lq_count;
  logic [LQ_DEPTH-1:0]       ent_valid;
  logic [LQ_DEPTH-1:0][4:0]  ent_rd;
  logic [LQ_DEPTH-1:0]       rd_hit;
  wb_entry_t                 lq_head, lq_push_entry;
  logic                      lq_push, lq_pop;
  logic                      hazard, alu_ready, alu_acc, ld_ready;

  wb_load_fifo #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk          (clk),
    .reset        (reset),
    .push_i       (lq_push),
    .push_entry_i (lq_push_entry),
    .pop_i        (lq_pop),
    .head_o       (lq_head),
    .count_o      (lq_count),
    .ent_valid_o  (ent_valid),
    .ent_rd_o     (ent_rd)
  );

  // An ALU write must not overtake an older queued load to the same register.
  for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_hit
    assign rd_hit[i] = ent_valid[i] && (ent_rd[i] == bus.alu_rd);
  end

  assign hazard    = (bus.alu_rd != 5'd0) && (|rd_hit);
  assign alu_ready = (state_q != WB_HALTED) && !hazard;
  assign alu_acc   = bus.alu_valid && alu_ready;
  assign ld_ready  = (state_q == WB_RUN) && (lq_count != CW'(LQ_DEPTH));
  assign lq_push   = bus.ld_valid && ld_ready;
  assign lq_pop    = (state_q != WB_HALTED) && !alu_acc && (lq_count != '0);

  assign lq_push_entry = '{rd:   bus.ld_rd,
                           data: wb_extend(bus.ld_data, ld_size_e'(bus.ld_size),
                                           bus.ld_unsigned)};

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (alu_acc) begin
      wr_en_d   = bus.alu_rd != 5'd0;
      wr_rd_d   = bus.alu_rd;
      wr_data_d = bus.alu_result;
    end else if (lq_pop) begin
      wr_en_d   = lq_head.rd != 5'd0;
      wr_rd_d   = lq_head.rd;
      wr_data_d = lq_head.data;
    end
    case (state_q)
      WB_RUN:   if (bus.halt_req) state_d = WB_DRAIN;
      WB_DRAIN: if ((lq_count == '0) && !alu_acc) state_d = WB_HALTED;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WB_RUN;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.alu_ready     = alu_ready;
  assign bus.ld_ready      = ld_ready;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_rd         = wr_rd_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.pending_count = lq_count;
  assign bus.halt_done     = state_q == WB_HALTED;

`ifdef WB_TRACE_EN
  logic wr_src_ld_q;

  always_ff @(posedge clk) begin
    if (reset) wr_src_ld_q <= 1'b0;
    else       wr_src_ld_q <= !alu_acc;
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en_q)
      $display("WB x%0d <= %h (%s)", wr_rd_q, wr_data_q, wr_src_ld_q ? "LD" : "ALU");
    if (!reset && (state_q != WB_HALTED) && (state_d == WB_HALTED))
      $display("WB halted");
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed table, corner sequences and random traffic, all
// cross-checked every cycle against a queue-based reference model.
module tb_writeback_unit;
  import riscv_wb_pkg::*;

  localparam int DW  = 64;
  localparam int LQD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_unit_if #(.BUS_DATA_WIDTH(DW), .LQ_DEPTH(LQD)) bus ();
  writeback_unit #(.BUS_DATA_WIDTH(DW), .LQ_DEPTH(LQD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending loads plus the expected write slot.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ment_t;

  ment_t       mq[$];
  int          m_state = 0;  // 0 run, 1 drain, 2 halted
  bit          m_wr_en = 1'b0;
  logic [4:0]  m_wr_rd = '0;
  logic [63:0] m_wr_data = '0;
  bit          m_live = 1'b0;

  function automatic logic [63:0] m_ext(logic [63:0] d, int sz, bit uns);
    int          bits;
    logic [63:0] mask, v;
    bits = 8 << sz;
    if (bits >= 64) return d;
    mask = (64'd1 << bits) - 64'd1;
    v = d & mask;
    if (!uns && d[bits-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    bit    hz, ar, lr, acc;
    int    n0;
    ment_t e;
    hz = 1'b0;
    for (int k = 0; k < mq.size(); k++)
      if (bus.alu_rd != 5'd0 && mq[k].rd == bus.alu_rd) hz = 1'b1;
    ar = (m_state != 2) && !hz;
    lr = (m_state == 0) && (mq.size() < LQD);
    if (m_live) begin
      check("alu_ready", bus.alu_ready, ar);
      check("ld_ready", bus.ld_ready, lr);
      check("pending_count", bus.pending_count, mq.size());
      check("halt_done", bus.halt_done, m_state == 2);
      check("wr_en", bus.wr_en, m_wr_en);
      if (m_wr_en) begin
        check("wr_rd", bus.wr_rd, m_wr_rd);
        check("wr_data", bus.wr_data, m_wr_data);
      end
    end
    if (reset) begin
      mq.delete();
      m_state = 0;
      m_wr_en = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      n0      = mq.size();
      acc     = bus.alu_valid && ar;
      m_wr_en = 1'b0;
      if (m_state != 2) begin
        if (acc) begin
          m_wr_en = bus.alu_rd != 5'd0;  m_wr_rd = bus.alu_rd;  m_wr_data = bus.alu_result;
        end else if (n0 > 0) begin
          e = mq.pop_front();
          m_wr_en = e.rd != 5'd0;  m_wr_rd = e.rd;  m_wr_data = e.data;
        end
        if (bus.ld_valid && lr) begin
          e.rd   = bus.ld_rd;
          e.data = m_ext(bus.ld_data, int'(bus.ld_size), bus.ld_unsigned);
          mq.push_back(e);
        end
        if (m_state == 0 && bus.halt_req) m_state = 1;
        else if (m_state == 1 && n0 == 0 && !acc) m_state = 2;
      end
    end
  end

  typedef struct {
    bit          is_ld;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [1:0]  size;
    bit          uns;
    logic [63:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.halt_req  = 1'b0;
  endtask

  task automatic drive_alu(logic [4:0] rd, logic [63:0] res);
    bus.alu_valid = 1'b1;  bus.alu_rd = rd;  bus.alu_result = res;
  endtask

  task automatic drive_ld(logic [4:0] rd, logic [63:0] d, logic [1:0] sz, bit uns);
    bus.ld_valid = 1'b1;  bus.ld_rd = rd;  bus.ld_data = d;
    bus.ld_size  = sz;    bus.ld_unsigned = uns;
  endtask

  task automatic check_wr(string name, logic [4:0] rd, logic [63:0] d);
    check({name, "_en"}, bus.wr_en, 1'b1);
    check({name, "_rd"}, bus.wr_rd, rd);
    check({name, "_data"}, bus.wr_data, d);
  endtask

  initial begin
    vec_t tbl[10];
    int   halted_cnt;

    reset = 1'b1;
    idle();
    bus.alu_rd = '0;  bus.alu_result = '0;  bus.ld_rd = '0;  bus.ld_data = '0;
    bus.ld_size = '0; bus.ld_unsigned = 1'b0;
    repeat (3) tick();
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_rd", bus.wr_rd, 5'd0);
    check("rst_wr_data", bus.wr_data, 64'd0);
    check("rst_pending", bus.pending_count, 3'd0);
    check("rst_halt_done", bus.halt_done, 1'b0);
    reset = 1'b0;
    tick();

    tbl[0] = '{1'b0, 5'd5,  64'h1234,                 2'd0, 1'b0, 64'h1234};
    tbl[1] = '{1'b1, 5'd1,  64'h80,                   2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
    tbl[2] = '{1'b1, 5'd2,  64'h8000_0000,            2'd2, 1'b1, 64'h0000_0000_8000_0000};
    tbl[3] = '{1'b1, 5'd3,  64'h7F,                   2'd0, 1'b0, 64'h7F};
    tbl[4] = '{1'b1, 5'd4,  64'hFFFF_8001,            2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8001};
    tbl[5] = '{1'b1, 5'd6,  64'h1234_8001,            2'd1, 1'b1, 64'h8001};
    tbl[6] = '{1'b1, 5'd8,  64'hFFFF_FFFF_7FFF_FFFF,  2'd2, 1'b0, 64'h7FFF_FFFF};
    tbl[7] = '{1'b1, 5'd10, 64'h8000_0000,            2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000};
    tbl[8] = '{1'b1, 5'd11, 64'h8000_0000_0000_0001,  2'd3, 1'b0, 64'h8000_0000_0000_0001};
    tbl[9] = '{1'b1, 5'd31, 64'hABCD_EF12_3456_78FE,  2'd0, 1'b1, 64'hFE};

    // ALU shows up one cycle later, loads two cycles later.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_ld) drive_ld(tbl[i].rd, tbl[i].data, tbl[i].size, tbl[i].uns);
      else              drive_alu(tbl[i].rd, tbl[i].data);
      tick();
      idle();
      if (tbl[i].is_ld) tick();
      check_wr($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].exp);
      tick();
    end

    // Hazard: queued load to x7 blocks an ALU write to x7 until the load retires.
    drive_ld(5'd7, 64'h11, 2'd3, 1'b0);
    tick();
    idle();
    drive_alu(5'd7, 64'h22);
    #1;
    check("haz_blocked", bus.alu_ready, 1'b0);
    tick();
    check_wr("haz_ld", 5'd7, 64'h11);
    #1;
    check("haz_released", bus.alu_ready, 1'b1);
    tick();
    idle();
    check_wr("haz_alu", 5'd7, 64'h22);
    tick();

    // Full queue behind a busy ALU, then drained in order.
    for (int i = 0; i < 4; i++) begin
      drive_alu(5'd9, 64'(i));
      drive_ld(5'(10 + i), 64'h100 + 64'(i), 2'd3, 1'b0);
      tick();
    end
    drive_ld(5'd14, 64'h104, 2'd3, 1'b0);
    #1;
    check("full_count", bus.pending_count, 3'd4);
    check("full_ld_ready", bus.ld_ready, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_wr($sformatf("drain%0d", i), 5'(10 + i), 64'h100 + 64'(i));
    end
    tick();

    // x0 from both sources: consumed, never written.
    drive_alu(5'd0, 64'hDEAD);
    drive_ld(5'd0, 64'h55, 2'd3, 1'b0);
    tick();
    idle();
    check("x0_alu_wr_en", bus.wr_en, 1'b0);
    check("x0_queued", bus.pending_count, 3'd1);
    tick();
    check("x0_ld_wr_en", bus.wr_en, 1'b0);
    check("x0_drained", bus.pending_count, 3'd0);
    tick();

    // Halt with two loads pending.
    for (int i = 0; i < 2; i++) begin
      drive_alu(5'd9, 64'h9);
      drive_ld(5'(20 + i), 64'h200 + 64'(i), 2'd3, 1'b0);
      tick();
    end
    idle();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    drive_ld(5'd22, 64'h202, 2'd3, 1'b0);
    #1;
    check("halt_ld_ready", bus.ld_ready, 1'b0);
    check_wr("halt_w0", 5'd20, 64'h200);
    tick();
    check_wr("halt_w1", 5'd21, 64'h201);
    check("halt_not_yet", bus.halt_done, 1'b0);
    tick();
    drive_alu(5'd3, 64'h33);
    for (int i = 0; i < 3; i++) begin
      check("halt_done", bus.halt_done, 1'b1);
      check("halted_wr_en", bus.wr_en, 1'b0);
      #1;
      check("halted_alu_ready", bus.alu_ready, 1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("halt_reset", bus.halt_done, 1'b0);
    tick();

    // Random traffic; small rd range forces frequent hazards.
    halted_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.alu_valid   = $urandom_range(0, 9) < 6;
      bus.alu_rd      = 5'($urandom_range(0, 7));
      bus.alu_result  = {$urandom, $urandom};
      bus.ld_valid    = $urandom_range(0, 2) != 0;
      bus.ld_rd       = 5'($urandom_range(0, 7));
      bus.ld_data     = {$urandom, $urandom};
      bus.ld_size     = 2'($urandom_range(0, 3));
      bus.ld_unsigned = $urandom_range(0, 1) != 0;
      bus.halt_req    = $urandom_range(0, 299) == 0;
      reset           = ($urandom_range(0, 499) == 0) || (halted_cnt > 4);
      tick();
      halted_cnt = (bus.halt_done === 1'b1) ? halted_cnt + 1 : 0;
    end
    reset = 1'b0;
    idle();
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
